// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared constants and helpers for the input conditioner.
// Holds the default debounce length, the default switch-bus width and the
// debounce counter width function used by every debounce channel.
package input_cond_pkg;

  // 1 ms of stable input at a 50 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  // Slide-switch bus width on the target board.
  localparam int SW_WIDTH_DEF = 8;

  // Counter width able to hold 0 .. cycles-1. Never narrower than 1 bit,
  // so the smallest legal setting (2 cycles) still gets a real counter.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : input_cond_pkg

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel: one push-button path.
// Raw level -> 2-flop synchronizer -> stable-count debouncer -> rise detect.
// level_o is the accepted (debounced) button state; rise_o is high for the
// single cycle in which level_o has just gone from 0 to 1.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;       // accepted stable button state
  logic          db_d;
  logic          db_prev_q;  // one-cycle delayed copy of db_q for edge detect
  logic [CW-1:0] cnt_q;      // consecutive samples that disagree with db_q
  logic [CW-1:0] cnt_d;

  // Next-state for the debouncer: count disagreeing samples, accept the new
  // level once DEBOUNCE_CYCLES of them have been seen in a row.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the if/else leaves a signal unassigned and infers a latch.
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;            // counter restarts from 0 via the default
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and edge-detect registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // with blocking ones the two synchronizer stages would collapse into one.
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign level_o = db_q;
  assign rise_o  = db_q & ~db_prev_q;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// input_conditioner: front end for the 8-bit multiplier processor.
// Cleans the Run and Reset_Load_Clear buttons into one-cycle request pulses,
// synchronizes the switch bus, and gates Run so one press starts at most one
// multiply. Clear always has priority over Run.
// Build option: define RUN_QUEUE_EN to hold one Run request that arrives
// while Busy=1 and issue it once Busy is seen low; by default such a Run
// press is dropped.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SW_WIDTH        = SW_WIDTH_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_Raw,
  input  logic                Clear_Raw,
  input  logic [SW_WIDTH-1:0] SW_Raw,
  input  logic                Busy,
  output logic                Run_Pulse,
  output logic                Clear_Pulse,
  output logic                Clear_Level,
  output logic [SW_WIDTH-1:0] SW_Sync
);

  logic                run_level;
  logic                run_rise;
  logic                clear_level;
  logic                clear_rise;

  logic                run_pulse_q;
  logic                run_pulse_d;
  logic                clear_pulse_q;
  logic [SW_WIDTH-1:0] sw_meta_q;
  logic [SW_WIDTH-1:0] sw_sync_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_run_ch (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .raw_i   (Run_Raw),
    .level_o (run_level),
    .rise_o  (run_rise)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_clear_ch (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .raw_i   (Clear_Raw),
    .level_o (clear_level),
    .rise_o  (clear_rise)
  );

  // The Run level itself is not exported; only its rise matters downstream.
  logic unused_run_level;
  assign unused_run_level = run_level;

`ifdef RUN_QUEUE_EN
  logic pending_q;  // one Run request held back while the processor is busy
  logic pending_d;

  // Run gating with a single-entry hold: a press during Busy is remembered
  // and issued on the first cycle Busy is low. Clear cancels anything held.
  always_comb begin
    run_pulse_d = 1'b0;
    pending_d   = pending_q;
    if (clear_rise || clear_level) begin
      pending_d = 1'b0;
    end else if (run_rise) begin
      if (!Busy) begin
        run_pulse_d = 1'b1;
        pending_d   = 1'b0;
      end else begin
        pending_d   = 1'b1;        // absorbs repeats: depth stays 1
      end
    end else if (pending_q && !Busy) begin
      run_pulse_d = 1'b1;
      pending_d   = 1'b0;
    end
  end

  // Held-request flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  // Run gating: a press is issued only if the processor is idle and Clear is
  // neither rising nor held; anything else is dropped.
  always_comb begin
    run_pulse_d = run_rise & ~Busy & ~clear_rise & ~clear_level;
  end
`endif

  // Registered request pulses and the two-stage switch synchronizer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_pulse_q   <= 1'b0;
      clear_pulse_q <= 1'b0;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
    end else begin
      run_pulse_q   <= run_pulse_d;
      clear_pulse_q <= clear_rise;
      sw_meta_q     <= SW_Raw;
      sw_sync_q     <= sw_meta_q;
    end
  end

  assign Run_Pulse   = run_pulse_q;
  assign Clear_Pulse = clear_pulse_q;
  assign Clear_Level = clear_level;
  assign SW_Sync     = sw_sync_q;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
// A raw edge applied before clock edge N shows up as a debounced level after
// edge N+5 and as a request pulse after edge N+6. In table terms: inputs of
// row r act on edge r+1, outputs are observed 1 time unit after that edge.
module tb_input_conditioner;

  localparam int DC = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_raw;
  logic          clear_raw;
  logic [SW-1:0] sw_raw;
  logic          busy;
  logic          run_pulse;
  logic          clear_pulse;
  logic          clear_level;
  logic [SW-1:0] sw_sync;

  input_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .SW_WIDTH        (SW)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .Run_Raw     (run_raw),
    .Clear_Raw   (clear_raw),
    .SW_Raw      (sw_raw),
    .Busy        (busy),
    .Run_Pulse   (run_pulse),
    .Clear_Pulse (clear_pulse),
    .Clear_Level (clear_level),
    .SW_Sync     (sw_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          run;
    logic          clr;
    logic          busy;
    logic [SW-1:0] sw;
    logic          exp_rp;
    logic          exp_cp;
    logic          exp_cl;
    logic [SW-1:0] exp_sw;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic run, input logic clr, input logic bsy,
                     input logic [SW-1:0] sw, input logic rp, input logic cp,
                     input logic cl, input logic [SW-1:0] xsw);
    vec_t v;
    v.run = run; v.clr = clr; v.busy = bsy; v.sw = sw;
    v.exp_rp = rp; v.exp_cp = cp; v.exp_cl = cl; v.exp_sw = xsw;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  function automatic logic [31:0] outs();
    return {21'd0, run_pulse, clear_pulse, clear_level, sw_sync};
  endfunction

  // Idle n cycles with both buttons released; returns Run pulses seen.
  task automatic idle(input int n, output int pulses);
    pulses = 0;
    run_raw = 1'b0; clear_raw = 1'b0; busy = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      if (run_pulse) pulses++;
    end
  endtask

  // Press Run for `len` cycles then release; count Run pulses over 20 cycles.
  task automatic press_run(input int len, output int pulses);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      run_raw = (k < len);
      step();
      if (run_pulse) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int first;

    // Reset held 3 cycles with Run already pressed.
    rst = 1'b1; run_raw = 1'b1; clear_raw = 1'b0; sw_raw = 8'hFF; busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("outputs_in_reset", outs(), 32'd0);
    end
    rst = 1'b0;
    pulses = 0; first = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (run_pulse) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("post_reset_run_pulses", pulses, 1);
    check("post_reset_run_latency_ok", (first >= 5 && first <= 7), 1);

    // Release Run: a debounced fall must not produce a pulse.
    idle(12, pulses);
    check("no_pulse_on_release", pulses, 0);

    // Main table: SW sync latency, a clean Run press, held Run, simultaneous
    // Run+Clear, Clear level extension, Run while Clear held.
    add(1,  0,0,0,8'hFE, 0,0,0,8'hFF);
    add(1,  0,0,0,8'hFE, 0,0,0,8'hFE);
    add(6,  1,0,0,8'hFE, 0,0,0,8'hFE);
    add(1,  1,0,0,8'hFE, 1,0,0,8'hFE);
    add(4,  1,0,0,8'hFE, 0,0,0,8'hFE);
    add(7,  0,0,0,8'hFE, 0,0,0,8'hFE);
    add(5,  1,1,0,8'hFE, 0,0,0,8'hFE);
    add(1,  1,1,0,8'hFE, 0,0,1,8'hFE);
    add(1,  1,1,0,8'hFE, 0,1,1,8'hFE);
    add(3,  1,1,0,8'hFE, 0,0,1,8'hFE);
    add(5,  1,0,0,8'hFE, 0,0,1,8'hFE);
    add(1,  1,0,0,8'hFE, 0,0,0,8'hFE);
    add(8,  0,0,0,8'hFE, 0,0,0,8'hFE);
    add(5,  0,1,0,8'hFE, 0,0,0,8'hFE);
    add(1,  0,1,0,8'hFE, 0,0,1,8'hFE);
    add(1,  0,1,0,8'hFE, 0,1,1,8'hFE);
    add(10, 1,1,0,8'hFE, 0,0,1,8'hFE);
    add(5,  0,0,0,8'hFE, 0,0,1,8'hFE);
    add(4,  0,0,0,8'hFE, 0,0,0,8'hFE);

    for (int r = 0; r < tbl.size(); r++) begin
      run_raw = tbl[r].run; clear_raw = tbl[r].clr; busy = tbl[r].busy; sw_raw = tbl[r].sw;
      step();
      check($sformatf("row%0d", r), outs(),
            {21'd0, tbl[r].exp_rp, tbl[r].exp_cp, tbl[r].exp_cl, tbl[r].exp_sw});
    end

    // Glitches shorter than DEBOUNCE_CYCLES are ignored; exactly DC is accepted.
    idle(6, pulses);
    press_run(2, pulses);
    check("glitch2_no_pulse", pulses, 0);
    press_run(DC - 1, pulses);
    check("glitch3_no_pulse", pulses, 0);
    press_run(DC, pulses);
    check("press4_one_pulse", pulses, 1);
    idle(12, pulses);

    // Run pressed while Busy; Busy drops 10 cycles after the press.
    pulses = 0; first = -1;
    for (int k = 0; k < 30; k++) begin
      run_raw = 1'b1;
      busy    = (k < 10);
      step();
      if (run_pulse) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
`ifdef RUN_QUEUE_EN
    check("busy_queued_pulses", pulses, 1);
    check("busy_queued_pulse_cycle", first, 10);
`else
    check("busy_dropped_pulses", pulses, 0);
`endif
    idle(12, pulses);
    check("busy_release_no_pulse", pulses, 0);

    // Reset mid-debounce with Run still held: async clear of all outputs,
    // then the held button is re-accepted as exactly one new press.
    run_raw = 1'b1;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    #1;
    check("async_reset_outputs", outs(), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_reset_outputs", outs(), 32'd0);
    end
    rst = 1'b0;
    pulses = 0; first = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (run_pulse) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("mid_reset_run_pulses", pulses, 1);
    check("mid_reset_latency_ok", (first >= 5 && first <= 7), 1);
    check("mid_reset_sw_resync", {24'd0, sw_sync}, 32'h0000_00FE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_input_conditioner
